// File: rtl/conv2d_stream.sv
// Streaming valid-correlation 2-D convolution engine.
// K-1 line buffers feed a KxK window; each accepted pixel at row>=K-1,
// col>=K-1 yields one result per output channel into a single output register.

// Per-channel dot product of the next window with that channel's kernel.
module conv2d_lane #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 64,
    parameter int K      = 5
) (
    input  logic [K*K-1:0][DATA_W-1:0] win,
    input  logic [K*K-1:0][DATA_W-1:0] wgt,
    input  logic                       relu,
    output logic [DATA_W-1:0]          res
);
    logic signed [ACC_W-1:0] sum;

    // Sign-extend both operands to ACC_W before multiplying so the product is exact.
    always_comb begin
        sum = '0;
        for (int i = 0; i < K*K; i++) begin
            sum = sum + ($signed({{(ACC_W-DATA_W){win[i][DATA_W-1]}}, win[i]}) *
                         $signed({{(ACC_W-DATA_W){wgt[i][DATA_W-1]}}, wgt[i]}));
        end
        if (relu && (sum < 0)) res = '0;
        else                   res = sum[DATA_W-1:0];
    end
endmodule

module conv2d_stream #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 64,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int K      = 5,
    parameter int OUT_CH = 2,
    localparam int CH_W  = (OUT_CH > 1) ? $clog2(OUT_CH) : 1,
    localparam int IDX_W = (K*K > 1) ? $clog2(K*K) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     k_we,
    input  logic [CH_W-1:0]          k_ch,
    input  logic [IDX_W-1:0]         k_idx,
    input  logic [DATA_W-1:0]        k_data,
    input  logic                     relu_en,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_CH*DATA_W-1:0] out_data,
    output logic                     out_last,
    output logic                     busy
);
    localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int LB_N = (K > 1) ? K - 1 : 1;
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_K   = CW'(K - 1);
    localparam logic [RW-1:0] ROW_K   = RW'(K - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                                  state_q, state_d;
    logic [CW-1:0]                           col_q, col_d;
    logic [RW-1:0]                           row_q, row_d;
    logic                                    relu_q, relu_d;
    logic                                    out_valid_q, out_valid_d;
    logic [OUT_CH-1:0][DATA_W-1:0]           out_data_q, out_data_d;
    logic                                    out_last_q, out_last_d;
    logic [OUT_CH-1:0][K*K-1:0][DATA_W-1:0]  w_q, w_d;
    logic [K*K-1:0][DATA_W-1:0]              win_q, win_d;
    logic [DATA_W-1:0]                       lb_q [LB_N][IMG_W];
    logic [DATA_W-1:0]                       lb_d [LB_N][IMG_W];

    logic [K-1:0][DATA_W-1:0]                colv;
    logic [OUT_CH-1:0][DATA_W-1:0]           lane_res;
    logic                                    acc, produce, end_px, relu_cur;

    assign in_ready  = !rst && (state_q != DRAIN) && (!out_valid_q || out_ready);
    assign acc       = in_valid && in_ready;
    assign end_px    = (row_q == ROW_MAX) && (col_q == COL_MAX);
    assign produce   = acc && (row_q >= ROW_K) && (col_q >= COL_K);
    // The first pixel of a frame uses relu_en live; it is latched at the same edge.
    assign relu_cur  = (state_q == IDLE) ? relu_en : relu_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != IDLE);

    // Incoming window column: K-1 older rows from the line buffers, newest pixel at the bottom.
    always_comb begin
        colv = '0;
        for (int i = 0; i < K-1; i++) colv[i] = lb_q[i][col_q];
        colv[K-1] = in_data;
    end

    // Window shift and line-buffer rotation for an accepted pixel.
    always_comb begin
        win_d = win_q;
        lb_d  = lb_q;
        if (acc) begin
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K-1; j++) win_d[i*K+j] = win_q[i*K+j+1];
                win_d[i*K+K-1] = colv[i];
            end
            for (int i = 0; i < K-1; i++) lb_d[i][col_q] = colv[i+1];
        end
    end

    generate
        for (genvar c = 0; c < OUT_CH; c++) begin : g_lane
            conv2d_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W), .K(K)) u_lane (
                .win  (win_d),
                .wgt  (w_q[c]),
                .relu (relu_cur),
                .res  (lane_res[c])
            );
        end
    endgenerate

    // Control: FSM, raster counters, kernel writes and the output register.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        relu_d      = relu_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        w_d         = w_q;

        if (k_we && (state_q == IDLE)) begin
            for (int c = 0; c < OUT_CH; c++)
                for (int i = 0; i < K*K; i++)
                    if ((k_ch == CH_W'(c)) && (k_idx == IDX_W'(i))) w_d[c][i] = k_data;
        end

        if (acc) begin
            if (col_q == COL_MAX) begin
                col_d = '0;
                row_d = (row_q == ROW_MAX) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
            if (state_q == IDLE) relu_d = relu_en;
            if (end_px)                 state_d = DRAIN;
            else if (state_q == IDLE)   state_d = RUN;
        end

        if (produce) begin
            out_valid_d = 1'b1;
            out_data_d  = lane_res;
            out_last_d  = end_px;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if ((state_q == DRAIN) && out_valid_q && out_ready && out_last_q) state_d = IDLE;
    end

    // Control and kernel state, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            relu_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            w_q         <= '0;
            win_q       <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            relu_q      <= relu_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            w_q         <= w_d;
            win_q       <= win_d;
        end
    end

    // Line buffers need no reset: stale rows are flushed before any result uses them.
    always_ff @(posedge clk) begin
        lb_q <= lb_d;
    end
endmodule

// File: tb/tb_conv2d_stream.sv
// Bench for conv2d_stream: table of frame scenarios plus a mid-frame reset sequence.
module tb_conv2d_stream;
    localparam int DW = 32, IW = 28, IH = 28, KK = 5, NC = 2;
    localparam int NRES = (IH-KK+1)*(IW-KK+1);
    localparam int NPIX = IW*IH;

    logic              clk = 1'b0;
    logic              rst;
    logic              k_we;
    logic [0:0]        k_ch;
    logic [4:0]        k_idx;
    logic [DW-1:0]     k_data;
    logic              relu_en;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     in_data;
    logic              out_valid;
    logic              out_ready;
    logic [NC*DW-1:0]  out_data;
    logic              out_last;
    logic              busy;

    conv2d_stream #(.DATA_W(DW), .ACC_W(64), .IMG_W(IW), .IMG_H(IH), .K(KK), .OUT_CH(NC)) dut (
        .clk(clk), .rst(rst), .k_we(k_we), .k_ch(k_ch), .k_idx(k_idx), .k_data(k_data),
        .relu_en(relu_en), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [NC*DW-1:0] data; logic last; } exp_t;
    typedef struct {
        int img; int wk; bit relu; bit tog; bit lock; int rdy;
        bit has_c; logic [31:0] c0; logic [31:0] c1;
    } vec_t;

    exp_t q[$];
    int   img [IH][IW];
    int   mw  [NC][KK*KK];
    int   checks = 0, failures = 0;

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic logic [NC*DW-1:0] model(input int r, input int s, input bit relu);
        logic [NC*DW-1:0] res;
        longint sum;
        res = '0;
        for (int c = 0; c < NC; c++) begin
            sum = 0;
            for (int i = 0; i < KK; i++)
                for (int j = 0; j < KK; j++)
                    sum += longint'(img[r+i][s+j]) * longint'(mw[c][i*KK+j]);
            if (relu && sum < 0) sum = 0;
            res[c*DW +: DW] = sum[31:0];
        end
        return res;
    endfunction

    // kind: -2 impulse at (0,0), -1 ramp r*IW+c, otherwise constant fill
    task automatic fill_img(input int kind);
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++)
                img[r][c] = (kind == -1) ? r*IW + c : (kind == -2) ? 0 : kind;
        if (kind == -2) img[0][0] = 1;
    endtask

    task automatic write_w(input int ch, input int idx, input int d);
        @(negedge clk);
        k_we = 1'b1; k_ch = ch[0:0]; k_idx = idx[4:0]; k_data = d;
        @(negedge clk);
        k_we = 1'b0;
    endtask

    // kind 0: w[0][0]=1; kind 1: ch0 all ones, ch1 centre 3; kind 2: w[0][0]=-1
    task automatic set_weights(input int kind);
        int v;
        for (int c = 0; c < NC; c++)
            for (int i = 0; i < KK*KK; i++) begin
                v = 0;
                if (kind == 0 && c == 0 && i == 0) v = 1;
                if (kind == 1 && c == 0) v = 1;
                if (kind == 1 && c == 1 && i == 12) v = 3;
                if (kind == 2 && c == 0 && i == 0) v = -1;
                mw[c][i] = v;
                write_w(c, i, v);
            end
        write_w(0, 25, 7);   // out-of-range index, must not land anywhere
    endtask

    task automatic run_frame(input int rdy, input bit relu, input bit tog, input bit lock,
                             input int abort_n, input bit has_c,
                             input logic [31:0] c0, input logic [31:0] c1);
        int sent = 0, nres = 0, cyc = 0, cbad = 0, r, c;
        bit started = 0, busy_chk = 0, stalled = 0, in_hs, out_hs;
        logic [NC*DW-1:0] sd;
        logic sl;
        exp_t e;
        chk(busy === 1'b0, "busy_idle", 64'(busy), 0);
        relu_en = relu;
        while (nres < NRES && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (abort_n > 0 && sent >= abort_n) break;
            if (started && tog) relu_en = ~relu_en;
            k_we = lock && sent >= 10 && sent < 20;
            k_ch = 1'b0; k_idx = 5'd0; k_data = 32'd9;
            if (sent < NPIX && $urandom_range(0, 99) < ((rdy == 100) ? 100 : 80)) begin
                in_valid = 1'b1;
                in_data  = img[sent / IW][sent % IW];
            end else begin
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 99) < rdy);
            #1;
            if (started && !busy_chk) begin
                chk(busy === 1'b1, "busy_run", 64'(busy), 1);
                busy_chk = 1;
            end
            if (stalled)
                chk(out_valid === 1'b1 && out_data === sd && out_last === sl, "stall_hold", out_data, sd);
            stalled = out_valid && !out_ready;
            sd = out_data; sl = out_last;
            if (out_valid && !out_ready) chk(in_ready === 1'b0, "in_ready_full", 64'(in_ready), 0);
            in_hs  = in_valid && in_ready;
            out_hs = out_valid && out_ready;
            if (out_hs) begin
                if (q.size() == 0) chk(1'b0, "extra_result", out_data, 0);
                else begin
                    e = q.pop_front();
                    chk(out_data === e.data, "out_data", out_data, e.data);
                    chk(out_last === e.last, "out_last", 64'(out_last), 64'(e.last));
                    if (has_c && (out_data[31:0] !== c0 || out_data[63:32] !== c1)) cbad++;
                end
                nres++;
            end
            if (in_hs) begin
                r = sent / IW; c = sent % IW;
                if (r >= KK-1 && c >= KK-1) begin
                    e.data = model(r-KK+1, c-KK+1, relu);
                    e.last = (r == IH-1 && c == IW-1);
                    q.push_back(e);
                end
                sent++;
                started = 1;
            end
        end
        in_valid = 1'b0;
        k_we = 1'b0;
        if (abort_n == 0) begin
            chk(cyc < 20000, "frame_timeout", 64'(cyc), 20000);
            chk(nres == NRES, "result_count", 64'(nres), NRES);
            chk(q.size() == 0, "results_missing", 64'(q.size()), 0);
            if (has_c) chk(cbad == 0, "const_value", 64'(cbad), 0);
            @(negedge clk);
            #1;
            chk(busy === 1'b0, "busy_done", 64'(busy), 0);
        end
    endtask

    vec_t tv [9];

    initial begin
        rst = 1'b1; k_we = 0; k_ch = 0; k_idx = 0; k_data = 0; relu_en = 0;
        in_valid = 0; in_data = 0; out_ready = 0;
        tv[0] = '{-2,  0, 0, 0, 0, 100, 0, 32'h0,        32'h0};
        tv[1] = '{ 2,  1, 0, 0, 0, 100, 1, 32'd50,       32'd6};
        tv[2] = '{ 3,  2, 1, 0, 0, 100, 1, 32'h0,        32'h0};
        tv[3] = '{ 3,  2, 0, 0, 0, 100, 1, 32'hFFFFFFFD, 32'h0};
        tv[4] = '{ 3, -1, 1, 1, 0, 100, 1, 32'h0,        32'h0};
        tv[5] = '{ 3, -1, 0, 1, 0, 100, 1, 32'hFFFFFFFD, 32'h0};
        tv[6] = '{-1,  1, 0, 0, 0,  50, 0, 32'h0,        32'h0};
        tv[7] = '{-2,  0, 0, 0, 1, 100, 0, 32'h0,        32'h0};
        tv[8] = '{-2, -1, 0, 0, 0,  70, 0, 32'h0,        32'h0};

        #1;
        chk(in_ready === 1'b0,  "rst_in_ready",  64'(in_ready), 0);
        chk(out_valid === 1'b0, "rst_out_valid", 64'(out_valid), 0);
        chk(out_data === '0,    "rst_out_data",  out_data, 0);
        chk(out_last === 1'b0,  "rst_out_last",  64'(out_last), 0);
        chk(busy === 1'b0,      "rst_busy",      64'(busy), 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        chk(in_ready === 1'b1, "in_ready_after_rst", 64'(in_ready), 1);

        for (int i = 0; i < 9; i++) begin
            fill_img(tv[i].img);
            if (tv[i].wk >= 0) set_weights(tv[i].wk);
            run_frame(tv[i].rdy, tv[i].relu, tv[i].tog, tv[i].lock, 0, tv[i].has_c, tv[i].c0, tv[i].c1);
            if (tv[i].lock) begin
                write_w(0, 0, 9);
                mw[0][0] = 9;
            end
        end

        // Mid-frame reset: weights must clear, then a full frame runs cleanly.
        fill_img(-1);
        set_weights(1);
        run_frame(100, 0, 0, 0, 300, 0, 0, 0);
        rst = 1'b1;
        q.delete();
        #1;
        chk(busy === 1'b0,      "midrst_busy",      64'(busy), 0);
        chk(out_valid === 1'b0, "midrst_out_valid", 64'(out_valid), 0);
        chk(in_ready === 1'b0,  "midrst_in_ready",  64'(in_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < NC; c++)
            for (int i = 0; i < KK*KK; i++) mw[c][i] = 0;
        write_w(0, 0, 1);
        mw[0][0] = 1;
        run_frame(60, 0, 0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
